alu_nibble_sequencer: RTL and testbench

ALU_NIBBLE_SEQUENCER -- requirements
Module: alu_nibble_sequencer

---
 rtl/alu_nibble_sequencer_pkg.sv | 21 ++
 rtl/alu_nibble_sequencer_if.sv | 52 +++++
 rtl/alu_nibble_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_nibble_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : alu_seq_pkg
// Description : Shared constants and FSM state encoding for the nibble-serial
//               ALU sequencer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
package alu_seq_pkg;

  // Width of one slice handled by the external ALU
  localparam int NIBBLE_W = 4;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_nibble_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : alu_nibble_sequencer_if
// Description : Request, external-ALU and response signals of the nibble
//               sequencer. The sequencer uses the slave view; the environment
//               (requester, ALU, consumer) uses the master view.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
interface alu_nibble_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  // Request channel
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [1:0]   req_s;
  logic         req_cin;

  // External 4-bit ALU
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic [1:0]   alu_s;
  logic         alu_cin;
  logic [3:0]   alu_y;
  logic         alu_cout;

  // Response channel and status
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_y;
  logic         rsp_cout;
  logic         busy;

  modport slave (
    input  req_valid, req_a, req_b, req_s, req_cin,
    input  alu_y, alu_cout, rsp_ready,
    output req_ready, alu_a, alu_b, alu_s, alu_cin,
    output rsp_valid, rsp_y, rsp_cout, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_s, req_cin,
    output alu_y, alu_cout, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_s, alu_cin,
    input  rsp_valid, rsp_y, rsp_cout, busy
  );

endinterface
`default_nettype wire

// File: rtl/alu_nibble_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : alu_nibble_sequencer
// Description : Feeds a W-bit operation through an external 4-bit ALU one
//               nibble per clock, forwarding the carry between slices and
//               assembling the W-bit result for a valid/ready consumer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_nibble_sequencer_if.slave bus
);

  localparam int              W      = NIBBLES * NIBBLE_W;
  localparam int              KW     = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0]   K_LAST = KW'(NIBBLES - 1);

  state_t         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [W-1:0]   a_q, b_q, y_q;
  logic [1:0]     s_q;
  // Holds the latched carry-in until slice 0 runs, then each slice's carry-out
  logic           carry_q;

  logic                w_accept;
  logic                w_run;
  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;

  assign w_accept = (state_q == ST_IDLE) && bus.req_valid;
  assign w_run    = (state_q == ST_RUN);
  assign w_a_nib  = a_q[int'(k_q) * NIBBLE_W +: NIBBLE_W];
  assign w_b_nib  = b_q[int'(k_q) * NIBBLE_W +: NIBBLE_W];

  // State and slice-index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic: one slice per RUN cycle, hold in DONE until consumed
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_d = ST_RUN;
          k_d     = '0;
        end
      end
      ST_RUN: begin
        // Last slice: stop here, k is not advanced past the top nibble
        if (k_q == K_LAST) begin
          state_d = ST_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        k_d     = '0;
      end
    endcase
  end

  // Operand capture on accept, result/carry capture on every RUN slice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      y_q     <= '0;
    end else if (w_accept) begin
      a_q     <= bus.req_a;
      b_q     <= bus.req_b;
      s_q     <= bus.req_s;
      carry_q <= bus.req_cin;
      y_q     <= '0;
    end else if (w_run) begin
      y_q[int'(k_q) * NIBBLE_W +: NIBBLE_W] <= bus.alu_y;
      carry_q                               <= bus.alu_cout;
    end
  end

  // ALU drive is active only while slicing; quiet zeros otherwise
  always_comb begin
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    bus.alu_s   = '0;
    bus.alu_cin = 1'b0;
    if (w_run) begin
      bus.alu_a   = w_a_nib;
      bus.alu_b   = w_b_nib;
      bus.alu_s   = s_q;
      bus.alu_cin = carry_q;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_DONE);
  assign bus.rsp_y     = y_q;
  assign bus.rsp_cout  = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_nibble_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_alu_nibble_sequencer
// Description : Self-checking bench for the nibble-serial ALU sequencer with a
//               behavioural 4-bit ALU on the alu_* ports.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_alu_nibble_sequencer;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  typedef struct {
    logic [W-1:0]       a;
    logic [W-1:0]       b;
    logic [1:0]         s;
    logic               cin;
    logic [W-1:0]       exp_y;
    logic               exp_cout;
    logic [NIBBLES-1:0] exp_cins;   // alu_cin seen in slice 0..3 (bit k)
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int errors  = 0;
  int checks  = 0;
  int accepts = 0;

  alu_nibble_sequencer_if #(.NIBBLES(NIBBLES)) bus ();

  alu_nibble_sequencer #(.NIBBLES(NIBBLES)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: s=0 add with carry, s=1 AND with carry passed through
  always_comb begin
    {bus.alu_cout, bus.alu_y} = 5'd0;
    case (bus.alu_s)
      2'd0:    {bus.alu_cout, bus.alu_y} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'd0, bus.alu_cin};
      2'd1:    {bus.alu_cout, bus.alu_y} = {bus.alu_cin, bus.alu_a & bus.alu_b};
      default: {bus.alu_cout, bus.alu_y} = {1'b0, bus.alu_a ^ bus.alu_b};
    endcase
  end

  // Count every accepted request
  always @(posedge clk) begin
    if (rst_n && bus.req_valid && bus.req_ready) accepts <= accepts + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rsp_y"},     32'(bus.rsp_y),     32'd0);
    chk({tag, "_rsp_cout"},  32'(bus.rsp_cout),  32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_alu_out"},   32'({bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_cin}), 32'd0);
  endtask

  // Called at a negedge; n = number of edges from the accept edge to the
  // first edge at which rsp_valid is presented (0 if it never appears)
  task automatic wait_rsp(output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      if (bus.rsp_valid) begin
        n = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic do_vec(input vec_t v, input string tag);
    int                 lat;
    logic [NIBBLES-1:0] cins;
    lat  = 0;
    cins = '0;
    @(negedge clk);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_a     = v.a;
    bus.req_b     = v.b;
    bus.req_s     = v.s;
    bus.req_cin   = v.cin;
    bus.req_valid = 1'b1;
    @(posedge clk);                       // accept edge T
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (bus.rsp_valid) begin
        lat = n;
        break;
      end
      if (n <= NIBBLES) cins[n-1] = bus.alu_cin;
      @(negedge clk);
    end
    chk({tag, "_latency"},  32'(lat),           32'd5);
    chk({tag, "_alu_cin"},  32'(cins),          32'(v.exp_cins));
    chk({tag, "_rsp_y"},    32'(bus.rsp_y),     32'(v.exp_y));
    chk({tag, "_rsp_cout"}, 32'(bus.rsp_cout),  32'(v.exp_cout));
    chk({tag, "_busy"},     32'(bus.busy),      32'd1);
    chk({tag, "_alu_idle"}, 32'({bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_cin}), 32'd0);
    handshake();
    chk({tag, "_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(bus.req_ready), 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    int acc0;
    int stray;

    vecs[0] = '{16'h0003, 16'h0005, 2'd0, 1'b0, 16'h0008, 1'b0, 4'b0000};
    vecs[1] = '{16'h00FF, 16'h0001, 2'd0, 1'b0, 16'h0100, 1'b0, 4'b0110};
    vecs[2] = '{16'hFFFF, 16'h0001, 2'd0, 1'b0, 16'h0000, 1'b1, 4'b1110};
    vecs[3] = '{16'hFFFF, 16'h0000, 2'd0, 1'b1, 16'h0000, 1'b1, 4'b1111};
    vecs[4] = '{16'h1234, 16'h1111, 2'd0, 1'b0, 16'h2345, 1'b0, 4'b0000};
    vecs[5] = '{16'h8000, 16'h8000, 2'd0, 1'b0, 16'h0000, 1'b1, 4'b0000};
    vecs[6] = '{16'h0F0F, 16'h0101, 2'd0, 1'b1, 16'h1011, 1'b0, 4'b1011};
    vecs[7] = '{16'hF0F0, 16'h3C3C, 2'd1, 1'b1, 16'h3030, 1'b1, 4'b1111};

    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_s     = '0;
    bus.req_cin   = 1'b0;
    bus.rsp_ready = 1'b0;
    rst_n         = 1'b0;
    #12;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven operations
    for (int i = 0; i < 8; i++) begin
      do_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-pressure in DONE, then back-to-back accept with req_valid held high
    @(negedge clk);
    acc0          = accepts;
    bus.req_a     = 16'h0003;
    bus.req_b     = 16'h0005;
    bus.req_s     = 2'd0;
    bus.req_cin   = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_a = 16'h0100;
    bus.req_b = 16'h0200;
    wait_rsp(n);
    chk("bp_latency", 32'(n), 32'd5);
    for (int i = 0; i < 3; i++) begin
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_y",     32'(bus.rsp_y),     32'h0008);
      chk("bp_rsp_cout",  32'(bus.rsp_cout),  32'd0);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    chk("bp_one_accept", 32'(accepts - acc0), 32'd1);
    handshake();
    chk("b2b_idle_after_hs", 32'(bus.busy), 32'd0);
    chk("b2b_no_accept_at_hs", 32'(accepts - acc0), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_accept_next_edge", 32'(accepts - acc0), 32'd2);
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    bus.req_valid = 1'b0;
    wait_rsp(n);
    chk("b2b_latency", 32'(n), 32'd5);
    chk("b2b_rsp_y",   32'(bus.rsp_y), 32'h0300);
    handshake();

    // Asynchronous reset during slice 2 discards the operation
    @(negedge clk);
    bus.req_a     = 16'hFFFF;
    bus.req_b     = 16'h0001;
    bus.req_cin   = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);                       // slice 2 on the ALU
    chk("rst_in_run_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_async");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) stray++;
    end
    chk("rst_no_rsp", 32'(stray), 32'd0);
    do_vec(vecs[4], "post_rst");

    // req_valid toggling with other operands while an op is in flight
    @(negedge clk);
    acc0          = accepts;
    bus.req_a     = 16'h00FF;
    bus.req_b     = 16'h0001;
    bus.req_cin   = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      bus.req_valid = i[0];
      bus.req_a     = 16'hA5A5 ^ 16'(i);
      bus.req_b     = 16'h5A5A + 16'(i);
      bus.req_cin   = i[1];
      if (bus.rsp_valid) begin
        n = i;
        break;
      end
    end
    chk("tog_latency", 32'(n), 32'd5);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.req_valid = ~bus.req_valid;
    end
    chk("tog_rsp_y",    32'(bus.rsp_y),    32'h0100);
    chk("tog_rsp_cout", 32'(bus.rsp_cout), 32'd0);
    bus.req_valid = 1'b0;
    handshake();
    chk("tog_single_accept", 32'(accepts - acc0), 32'd1);
    chk("tog_idle", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
